// File: rtl/decode_opcode_align.sv
// decode_opcode_align: strips prefixes, decodes opcode/ModR/M fields and
// buffers decoded entries in a two-deep skid buffer with registered handshakes.
module decode_opcode_align #(
    parameter int QUEUE_BYTES  = 16,
    parameter int MAX_PREFIX   = 4,
    parameter int OPCODE_BYTES = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_flush,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [7:0]                        i_instruction [0:QUEUE_BYTES-1],
    input  logic [$clog2(MAX_PREFIX+1):0]     i_prefix_count,
    input  logic                              i_error_stage_2,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [7:0]                        o_opcode [0:OPCODE_BYTES-1],
    output logic                              o_two_byte,
    output logic                              o_mod_rm_is_present,
    output logic [1:0]                        o_mod,
    output logic [2:0]                        o_reg,
    output logic [2:0]                        o_rm,
    output logic                              o_w,
    output logic                              o_s,
    output logic                              o_s_is_present,
    output logic [1:0]                        o_consume_bytes,
    output logic                              o_error_stage_3
);
    localparam int PW = $clog2(MAX_PREFIX+1) + 1;
    localparam logic [PW-1:0] MAXP = PW'(MAX_PREFIX);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [OPCODE_BYTES-1:0][7:0] op;
        logic                         two;
        logic                         mrp;
        logic [1:0]                   md;
        logic [2:0]                   rg;
        logic [2:0]                   rm;
        logic                         w;
        logic                         s;
        logic                         sp;
        logic [1:0]                   cons;
        logic                         err;
    } entry_t;

    state_t        r_state;
    entry_t        r_out, r_skid, w_new;
    logic          r_valid, r_ready;
    logic          w_illegal, w_push, w_pop, w_unused;
    logic [PW-1:0] w_base;
    logic [7:0]    w_p, w_m;

    always_comb begin
        w_illegal = i_prefix_count > MAXP;
        w_base    = w_illegal ? '0 : i_prefix_count;
        w_new     = '0;
        // Legal prefix counts are bounded, so the shift is a small constant mux.
        for (int p = 0; p <= MAX_PREFIX; p++)
            if (w_base == PW'(p))
                for (int k = 0; k < OPCODE_BYTES; k++)
                    w_new.op[k] = i_instruction[p+k];
        w_new.two  = w_new.op[0] == 8'h0F;
        w_p        = w_new.two ? w_new.op[1] : w_new.op[0];
        w_m        = w_new.two ? w_new.op[2] : w_new.op[1];
        w_new.mrp  = w_new.two ? (w_p[7:4] != 4'h8)
                               : ((w_p <= 8'h3F && !w_p[2]) || w_p[7:4] == 4'h8 ||
                                  w_p inside {8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hD2, 8'hD3,
                                              8'hF6, 8'hF7, 8'hFE, 8'hFF});
        w_new.md   = w_new.mrp ? w_m[7:6] : 2'd0;
        w_new.rg   = w_new.mrp ? w_m[5:3] : 3'd0;
        w_new.rm   = w_new.mrp ? w_m[2:0] : 3'd0;
        w_new.w    = w_p[0];
        w_new.sp   = w_p[7:2] == 6'b100000;
        w_new.s    = w_new.sp & w_p[1];
        w_new.cons = 2'd1 + {1'b0, w_new.two} + {1'b0, w_new.mrp};
        w_new.err  = i_error_stage_2 | w_illegal;
        w_unused   = 1'b0;
        for (int j = 0; j < QUEUE_BYTES; j++)
            w_unused = w_unused ^ (^i_instruction[j]);
    end

    assign w_push = i_valid && r_ready;
    assign w_pop  = r_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_out   <= '0;
            r_skid  <= '0;
        end else if (i_flush) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: if (w_push) begin
                    r_out   <= w_new;
                    r_state <= ONE;
                    r_valid <= 1'b1;
                end
                ONE: if (w_push && w_pop) begin
                    r_out <= w_new;
                end else if (w_push) begin
                    r_skid  <= w_new;
                    r_state <= FULL;
                    r_ready <= 1'b0;
                end else if (w_pop) begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                end
                FULL: if (w_pop) begin
                    r_out   <= r_skid;
                    r_state <= ONE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb
        for (int k = 0; k < OPCODE_BYTES; k++)
            o_opcode[k] = r_out.op[k];

    assign o_ready             = r_ready;
    assign o_valid             = r_valid;
    assign o_two_byte          = r_out.two;
    assign o_mod_rm_is_present = r_out.mrp;
    assign o_mod               = r_out.md;
    assign o_reg               = r_out.rg;
    assign o_rm                = r_out.rm;
    assign o_w                 = r_out.w;
    assign o_s                 = r_out.s;
    assign o_s_is_present      = r_out.sp;
    assign o_consume_bytes     = r_out.cons;
    assign o_error_stage_3     = r_out.err;
endmodule

// File: tb/tb_decode_opcode_align.sv
// tb_decode_opcode_align: directed, per-scenario checks of decode and skid buffering.
module tb_decode_opcode_align;
    logic       clk, rst_n, flush, in_valid, out_ready, err2, out_valid, dn_ready;
    logic [7:0] instr [0:15];
    logic [3:0] pcount;
    logic [7:0] opc [0:3];
    logic       two, mrp, w, s, sp, err3;
    logic [1:0] md, cons;
    logic [2:0] rg, rm;
    int         checks = 0;
    int         errors = 0;

    decode_opcode_align dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(in_valid),
        .o_ready(out_ready), .i_instruction(instr), .i_prefix_count(pcount),
        .i_error_stage_2(err2), .o_valid(out_valid), .i_ready(dn_ready),
        .o_opcode(opc), .o_two_byte(two), .o_mod_rm_is_present(mrp),
        .o_mod(md), .o_reg(rg), .o_rm(rm), .o_w(w), .o_s(s),
        .o_s_is_present(sp), .o_consume_bytes(cons), .o_error_stage_3(err3)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int st, input logic [31:0] v);
        for (int k = 0; k < 16; k++) instr[k] = 8'hAA;
        for (int k = 0; k < 4; k++) instr[st+k] = v[31-8*k -: 8];
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; in_valid = 0; err2 = 0; dn_ready = 1; pcount = 0;
        load(0, 32'h0);
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", out_ready); end
        checks++; if (opc[0] !== 8'h00 || cons !== 2'd0 || err3 !== 1'b0) begin errors++; $display("FAIL reset_data got %h %0d %b exp 00 0 0", opc[0], cons, err3); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_modrm();
        load(2, 32'h01D81122); pcount = 2; in_valid = 1;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL modrm_valid got %b exp 1", out_valid); end
        checks++; if (opc[0] !== 8'h01 || opc[1] !== 8'hD8) begin errors++; $display("FAIL modrm_opcode got %h %h exp 01 d8", opc[0], opc[1]); end
        checks++; if ({md, rg, rm} !== {2'd3, 3'd3, 3'd0}) begin errors++; $display("FAIL modrm_fields got %0d %0d %0d exp 3 3 0", md, rg, rm); end
        checks++; if (w !== 1'b1 || cons !== 2'd2 || two !== 1'b0 || mrp !== 1'b1 || err3 !== 1'b0) begin errors++; $display("FAIL modrm_flags got w%b c%0d t%b m%b e%b exp w1 c2 t0 m1 e0", w, cons, two, mrp, err3); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modrm_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_two_byte();
        load(0, 32'h0F840000); pcount = 0; in_valid = 1;
        tick();
        in_valid = 0;
        checks++; if (two !== 1'b1 || mrp !== 1'b0 || cons !== 2'd2) begin errors++; $display("FAIL two_byte got t%b m%b c%0d exp t1 m0 c2", two, mrp, cons); end
        checks++; if (w !== 1'b0 || sp !== 1'b0 || md !== 2'd0) begin errors++; $display("FAIL two_byte_fields got w%b sp%b mod%0d exp 0 0 0", w, sp, md); end
        tick();
    endtask

    task automatic test_sign_and_short();
        load(1, 32'h83C10000); pcount = 1; in_valid = 1;
        tick();
        checks++; if (sp !== 1'b1 || s !== 1'b1 || w !== 1'b1) begin errors++; $display("FAIL sign got sp%b s%b w%b exp 1 1 1", sp, s, w); end
        checks++; if ({md, rg, rm} !== {2'd3, 3'd0, 3'd1} || cons !== 2'd2) begin errors++; $display("FAIL sign_modrm got %0d %0d %0d c%0d exp 3 0 1 c2", md, rg, rm, cons); end
        load(0, 32'h05C10000); pcount = 0;
        tick();
        in_valid = 0;
        checks++; if (mrp !== 1'b0 || cons !== 2'd1 || w !== 1'b1 || sp !== 1'b0 || s !== 1'b0) begin errors++; $display("FAIL short got m%b c%0d w%b sp%b s%b exp 0 1 1 0 0", mrp, cons, w, sp, s); end
        tick();
    endtask

    task automatic test_error();
        load(0, 32'h04112233); pcount = 5; in_valid = 1;
        tick();
        checks++; if (err3 !== 1'b1 || opc[0] !== 8'h04 || opc[3] !== 8'h33) begin errors++; $display("FAIL err_illegal got e%b %h %h exp 1 04 33", err3, opc[0], opc[3]); end
        load(0, 32'h04112233); pcount = 0; err2 = 1;
        tick();
        checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL err_stage2 got %b exp 1", err3); end
        err2 = 0;
        tick();
        in_valid = 0;
        checks++; if (err3 !== 1'b0 || cons !== 2'd1) begin errors++; $display("FAIL err_clean got e%b c%0d exp 0 1", err3, cons); end
        tick();
    endtask

    task automatic test_back_to_back();
        dn_ready = 0; pcount = 0;
        load(0, 32'h04000000); in_valid = 1;
        tick();
        load(0, 32'h14000000);
        tick();
        checks++; if (out_ready !== 1'b0 || opc[0] !== 8'h04) begin errors++; $display("FAIL b2b_full got r%b %h exp 0 04", out_ready, opc[0]); end
        load(0, 32'h24000000);
        tick();
        tick();
        checks++; if (opc[0] !== 8'h04 || out_valid !== 1'b1 || cons !== 2'd1) begin errors++; $display("FAIL b2b_hold got %h v%b exp 04 1", opc[0], out_valid); end
        dn_ready = 1;
        tick();
        checks++; if (opc[0] !== 8'h14 || out_ready !== 1'b1) begin errors++; $display("FAIL b2b_second got %h r%b exp 14 1", opc[0], out_ready); end
        tick();
        in_valid = 0;
        checks++; if (opc[0] !== 8'h24 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_third got %h v%b exp 24 1", opc[0], out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        dn_ready = 0; pcount = 0;
        load(0, 32'h04000000); in_valid = 1;
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++; $display("FAIL flush got v%b r%b exp 0 1", out_valid, out_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stay got %b exp 0", out_valid); end
        dn_ready = 1;
    endtask

    task automatic test_async_reset();
        dn_ready = 0; pcount = 0;
        load(0, 32'h83C10000); in_valid = 1;
        tick();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++; $display("FAIL arst_hs got v%b r%b exp 0 1", out_valid, out_ready); end
        checks++; if (opc[0] !== 8'h00 || md !== 2'd0 || cons !== 2'd0 || w !== 1'b0) begin errors++; $display("FAIL arst_data got %h %0d %0d %b exp 00 0 0 0", opc[0], md, cons, w); end
        #1 rst_n = 1;
        dn_ready = 1;
        load(0, 32'h14000000); in_valid = 1;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || opc[0] !== 8'h14) begin errors++; $display("FAIL arst_resume got v%b %h exp 1 14", out_valid, opc[0]); end
        tick();
    endtask

    initial begin
        test_reset();
        test_modrm();
        test_two_byte();
        test_sign_and_short();
        test_error();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_opcode_align.md
DECODE_OPCODE_ALIGN -- requirements
Module: decode_opcode_align

Interface
REQ-001 SHALL have parameter QUEUE_BYTES, default 16: instruction queue window depth in bytes.
REQ-002 SHALL have parameter MAX_PREFIX, default 4: largest legal prefix count; QUEUE_BYTES >= MAX_PREFIX+OPCODE_BYTES.
REQ-003 SHALL have parameter OPCODE_BYTES, default 4: aligned bytes presented downstream.
REQ-004 SHALL have ports, in order:
- i_clk  in  1  sole clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous pipeline flush.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  block can accept an entry.
- i_instruction  in  8 x QUEUE_BYTES  byte array [0:QUEUE_BYTES-1].
- i_prefix_count  in  $clog2(MAX_PREFIX+1)+1  prefix bytes from stage 1.
- i_error_stage_2  in  1  upstream error.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_opcode  out  8 x OPCODE_BYTES  aligned bytes [0:OPCODE_BYTES-1].
- o_two_byte  out  1  escape byte 0x0F present.
- o_mod_rm_is_present  out  1.
- o_mod, o_reg, o_rm  out  2/3/3  ModR/M fields.
- o_w, o_s  out  1 each  width/sign-extend bits; o_s_is_present  out  1.
- o_consume_bytes  out  2  opcode+ModR/M byte count, 1..3.
- o_error_stage_3  out  1  accumulated error.

Function
REQ-005 SHALL accept an entry when i_valid && o_ready, sampled at i_clk rise.
REQ-006 SHALL hold entries in a 2-entry skid buffer (output register + skid register), states EMPTY, ONE, FULL.
REQ-007 SHALL drive o_ready = (state != FULL), registered, no combinational path from i_ready.
REQ-008 SHALL present an accepted entry on outputs with o_valid=1 exactly one cycle after acceptance when buffer was EMPTY or popped that cycle.
REQ-009 SHALL transition: EMPTY+push->ONE; ONE+push+pop->ONE (new entry on output); ONE+push,no pop->FULL (new entry in skid); ONE+pop->EMPTY; FULL+pop->ONE (skid moves to output); FULL without pop holds.
REQ-010 SHALL keep all outputs stable while o_valid && !i_ready.
REQ-011 SHALL align o_opcode[k] = i_instruction[i_prefix_count+k] for legal counts.
REQ-012 SHALL, when i_prefix_count > MAX_PREFIX, align from byte 0 and set o_error_stage_3.
REQ-013 SHALL set o_two_byte when byte0==8'h0F; primary opcode P = byte1 if two-byte else byte0; ModR/M byte M follows P.
REQ-014 SHALL set o_mod_rm_is_present for one-byte P in {00-3F with P[2]==0, 80-8F, C0, C1, D0-D3, F6, F7, FE, FF}; for two-byte all P except 80-8F.
REQ-015 SHALL output o_mod=M[7:6], o_reg=M[5:3], o_rm=M[2:0]; zero when ModR/M absent.
REQ-016 SHALL output o_w=P[0]; o_s=P[1] with o_s_is_present=1 only when P[7:2]==6'b100000, else o_s=0.
REQ-017 SHALL output o_consume_bytes = 1 + o_two_byte + o_mod_rm_is_present.
REQ-018 SHALL set o_error_stage_3 = i_error_stage_2 (registered with entry) OR REQ-012 condition.
REQ-019 SHALL, on i_flush, empty the buffer at that edge; flush overrides simultaneous push and pop; o_valid=0 and o_ready=1 next cycle.

Reset
REQ-020 SHALL, while i_reset_n=0, asynchronously force state EMPTY, o_valid=0, o_ready=1, all data outputs 0, including mid-transfer.
REQ-021 SHALL resume accepting on the first i_clk rise after i_reset_n deasserts.

Verification
REQ-022 SHALL cover: prefix_count=2, bytes[2..5]=01 D8 xx xx, i_ready=1 -> next cycle o_valid=1, o_opcode[0]=01, o_mod=3, o_reg=3, o_rm=0, o_w=1, o_consume_bytes=2.
REQ-023 SHALL cover: bytes 0F 84 ..., count 0 -> o_two_byte=1, o_mod_rm_is_present=0, o_consume_bytes=2.
REQ-024 SHALL cover: i_ready=0 with three pushes -> o_ready=0 after second; first entry held stable; releasing i_ready drains entries in order, no loss or duplication.
REQ-025 SHALL cover: count=MAX_PREFIX+1 -> o_error_stage_3=1, o_opcode[0]=i_instruction[0]; i_error_stage_2=1 with legal count -> o_error_stage_3=1.
REQ-026 SHALL cover: i_flush with simultaneous push while FULL -> next cycle o_valid=0, o_ready=1.
REQ-027 SHALL cover: i_reset_n pulsed low mid-stream asynchronously -> outputs zero immediately, o_ready=1.
